// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad path (scanner and decoder).
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL_1 = 4'b1000;
    localparam logic [3:0] COL_2 = 4'b0100;
    localparam logic [3:0] COL_3 = 4'b0010;
    localparam logic [3:0] COL_4 = 4'b0001;
    localparam logic [3:0] ROW_1 = 4'b1000;
    localparam logic [3:0] ROW_2 = 4'b0100;
    localparam logic [3:0] ROW_3 = 4'b0010;
    localparam logic [3:0] ROW_4 = 4'b0001;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Column 1 -> 2 -> 3 -> 4 -> 1 in the active-high one-hot encoding.
    function automatic logic [3:0] next_col(input logic [3:0] col);
        return {col[0], col[3:1]};
    endfunction

    function automatic logic single_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clk cycles.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with single-key debounce; define KEYPAD_AUTOREPEAT_EN
// to add auto-repeat key_valid pulses while a key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV           = 1000,
    parameter int DEBOUNCE_SCANS     = 8,
    parameter int REPEAT_DELAY_SCANS = 64,
    parameter int REPEAT_RATE_SCANS  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [7:0] key_index,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_SCANS);

    state_t        state;
    logic          tick;
    logic [3:0]    row_meta, row_sync, rs;
    logic [3:0]    col_sel;
    logic [7:0]    cand;
    logic [DW-1:0] dcnt, dcnt_inc;

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= ROWS_IDLE;
            row_sync <= ROWS_IDLE;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign rs       = ~row_sync;
    assign col_out  = ~col_sel;
    assign dcnt_inc = (dcnt == DEB_MAX) ? DEB_MAX : dcnt + DW'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ? REPEAT_DELAY_SCANS
                                                                   : REPEAT_RATE_SCANS;
    localparam int RW = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt, rcnt_inc, rlimit;
    logic          rep_on;

    // First repeat waits the long delay, later ones the shorter rate.
    assign rcnt_inc = rcnt + RW'(1);
    assign rlimit   = rep_on ? RW'(REPEAT_RATE_SCANS) : RW'(REPEAT_DELAY_SCANS);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_sel   <= COL_1;
            cand      <= '0;
            dcnt      <= '0;
            key_index <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rcnt      <= '0;
            rep_on    <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (single_hot(rs)) begin
                            cand  <= {col_sel, rs};
                            dcnt  <= '0;
                            state <= DEBOUNCE;
                        end else begin
                            col_sel <= next_col(col_sel);
                        end
                    end
                    DEBOUNCE: begin
                        if (rs == cand[3:0]) begin
                            dcnt <= dcnt_inc;
                            if (dcnt_inc == DEB_MAX) begin
                                key_index <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= HELD;
                            end
                        end else begin
                            state   <= SCAN;
                            col_sel <= next_col(col_sel);
                        end
                    end
                    HELD: begin
                        if (rs == 4'b0000) begin
                            dcnt  <= '0;
                            state <= RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rcnt   <= '0;
                            rep_on <= 1'b0;
                        end else if (rcnt_inc == rlimit) begin
                            key_valid <= 1'b1;
                            rcnt      <= '0;
                            rep_on    <= 1'b1;
                        end else begin
                            rcnt <= rcnt_inc;
`endif
                        end
                    end
                    RELEASE: begin
                        if (rs == 4'b0000) begin
                            dcnt <= dcnt_inc;
                            if (dcnt_inc == DEB_MAX) begin
                                key_held <= 1'b0;
                                state    <= SCAN;
                                col_sel  <= next_col(col_sel);
                            end
                        end else begin
                            dcnt  <= '0;
                            state <= HELD;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised bench for keypad_scanner against a tick-level behavioural keypad model.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RDELAY = 8;
    localparam int RRATE  = 4;
`else
    localparam int RDELAY = 64;
    localparam int RRATE  = 16;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [7:0] key_index;
    logic       key_valid;
    logic       key_held;

    // Physical key matrix: bit c*4+r is key at column c+1, row r+1.
    logic [15:0] pressed;

    keypad_scanner #(
        .SCAN_DIV           (SCAN_DIV),
        .DEBOUNCE_SCANS     (DEB),
        .REPEAT_DELAY_SCANS (RDELAY),
        .REPEAT_RATE_SCANS  (RRATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_index (key_index),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (!col_out[3-c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[c*4+r]) row_in[3-r] = 1'b0;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state, advanced once per scan tick.
    int         cyc;
    int         m_col;
    bit         m_tracking;
    logic [3:0] m_cand;
    int         m_streak;
    bit         m_held;
    bit         m_releasing;
    int         m_quiet;
    int         m_held_ticks;
    logic [7:0] m_index;
    bit         m_valid;

    function automatic logic [3:0] col_mask(input int c);
        logic [3:0] m;
        m = 4'b1000;
        return m >> c;
    endfunction

    function automatic logic [3:0] seen_rows();
        logic [3:0] v;
        v = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (pressed[m_col*4+r]) v[3-r] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_col = 0; m_tracking = 0; m_cand = 4'b0000; m_streak = 0;
        m_held = 0; m_releasing = 0; m_quiet = 0; m_held_ticks = 0;
        m_index = 8'h00; m_valid = 0;
    endtask

    task automatic model_tick();
        logic [3:0] rs;
        rs = seen_rows();
        if (!m_held) begin
            if (!m_tracking) begin
                if ($countones(rs) == 1) begin
                    m_tracking = 1; m_cand = rs; m_streak = 0;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (rs == m_cand) begin
                m_streak++;
                if (m_streak == DEB) begin
                    m_index = {col_mask(m_col), m_cand};
                    m_valid = 1; m_held = 1; m_tracking = 0;
                    m_releasing = 0; m_held_ticks = 0;
                end
            end else begin
                m_tracking = 0;
                m_col = (m_col + 1) % 4;
            end
        end else if (rs == 4'b0000) begin
            if (!m_releasing) begin
                m_releasing = 1; m_quiet = 0;
            end else begin
                m_quiet++;
                if (m_quiet == DEB) begin
                    m_held = 0; m_releasing = 0;
                    m_col = (m_col + 1) % 4;
                end
            end
        end else if (m_releasing) begin
            m_releasing = 0; m_held_ticks = 0;
        end else begin
            m_held_ticks++;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (m_held_ticks == RDELAY ||
                (m_held_ticks > RDELAY && (m_held_ticks - RDELAY) % RRATE == 0))
                m_valid = 1;
`endif
        end
    endtask

    task automatic compare_outputs();
        logic [3:0] exp_col;
        exp_col = ~col_mask(m_col);
        check("col_out", col_out, exp_col);
        check("key_index", key_index, m_index);
        check("key_valid", key_valid, m_valid);
        check("key_held", key_held, m_held);
    endtask

    // Advance to the cycle in which n more ticks have been modelled.
    task automatic run_ticks(input int n);
        int done;
        done = 0;
        while (done < n) begin
            @(negedge clk);
            cyc++;
            compare_outputs();
            m_valid = 0;
            if (cyc % SCAN_DIV == SCAN_DIV - 1) begin
                model_tick();
                done++;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_col_out", col_out, 4'b0111);
        check("rst_key_index", key_index, 8'h00);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    function automatic int key_bit(input int c, input int r);
        return c * 4 + r;
    endfunction

    initial begin
        int kind, c, r;
        rst = 1'b1;
        pressed = '0;
        model_reset();
        cyc = 0;
        @(negedge clk);
        do_reset();

        // Idle rotation, then a clean press of column 2 / row 3.
        run_ticks(8);
        pressed[key_bit(1, 2)] = 1'b1;
        run_ticks(25);
        pressed = '0;
        run_ticks(10);

        // Two keys in column 1 (rows 1 and 4) are rejected.
        pressed[key_bit(0, 0)] = 1'b1;
        pressed[key_bit(0, 3)] = 1'b1;
        run_ticks(12);
        pressed = '0;
        run_ticks(4);

        // Reset while held, key still down afterwards.
        pressed[key_bit(2, 1)] = 1'b1;
        run_ticks(14);
        do_reset();
        run_ticks(12);
        pressed = '0;
        run_ticks(8);

        for (int ep = 0; ep < 70; ep++) begin
            kind = $urandom_range(0, 5);
            c = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            pressed = '0;
            pressed[key_bit(c, r)] = 1'b1;
            case (kind)
                0: begin
                    run_ticks($urandom_range(6, 30));
                    pressed = '0;
                    run_ticks($urandom_range(1, 12));
                end
                1: begin
                    run_ticks($urandom_range(1, 4));
                    pressed = '0;
                    run_ticks($urandom_range(1, 3));
                end
                2: begin
                    pressed[$urandom_range(0, 15)] = 1'b1;
                    run_ticks($urandom_range(4, 20));
                    pressed = '0;
                    run_ticks($urandom_range(1, 6));
                end
                3: begin
                    run_ticks($urandom_range(8, 16));
                    pressed[$urandom_range(0, 15)] = 1'b1;
                    run_ticks($urandom_range(2, 8));
                    pressed = '0;
                    run_ticks($urandom_range(2, 10));
                end
                4: begin
                    run_ticks($urandom_range(3, 15));
                    do_reset();
                    run_ticks($urandom_range(5, 12));
                    pressed = '0;
                    run_ticks($urandom_range(1, 6));
                end
                default: begin
                    run_ticks(10);
                    pressed = '0;
                    run_ticks($urandom_range(1, 4));
                    pressed[key_bit(c, r)] = 1'b1;
                    run_ticks($urandom_range(3, 12));
                    pressed = '0;
                    run_ticks(8);
                end
            endcase
        end

        pressed = '0;
        run_ticks(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
